// File: rtl/alu_pkg.sv
// Shared constants for the ALU sharing controller: opcodes, PSR flag positions and FSM encoding.
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 5;
  localparam int FL_W   = 5;

  localparam logic [OP_W-1:0] OP_AND   = 5'b00001;
  localparam logic [OP_W-1:0] OP_OR    = 5'b00010;
  localparam logic [OP_W-1:0] OP_XOR   = 5'b00011;
  localparam logic [OP_W-1:0] OP_NOT   = 5'b00100;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b00101;
  localparam logic [OP_W-1:0] OP_ADDU  = 5'b00110;
  localparam logic [OP_W-1:0] OP_ADDC  = 5'b00111;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b01001;
  localparam logic [OP_W-1:0] OP_CMP   = 5'b01011;
  localparam logic [OP_W-1:0] OP_LSH   = 5'b01100;
  localparam logic [OP_W-1:0] OP_ADDCU = 5'b01111;
  localparam logic [OP_W-1:0] OP_RSH   = 5'b10011;
  localparam logic [OP_W-1:0] OP_ARSH  = 5'b10111;

  localparam int C_BIT = 4;
  localparam int L_BIT = 3;
  localparam int F_BIT = 2;
  localparam int Z_BIT = 1;
  localparam int N_BIT = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_XOR, OP_NOT, OP_ADD, OP_ADDU, OP_ADDC, OP_SUB,
      OP_CMP, OP_LSH, OP_ADDCU, OP_RSH, OP_ARSH: ok = 1'b1;
      default:                                  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time is granted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = gnt[1];
  end

  // Reset to 1 so requester 0 takes the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters: arbitration, operand
// registers, result capture, PSR ownership and a valid/ready response per requester.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int OPW   = OP_W,
  parameter int FLW   = FL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req_use_c,
  input  logic [1:0]       req_wr_psr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_opcode,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_c,
  input  logic [FLW-1:0]   alu_flags,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [FLW-1:0]   rsp_flags,
  output logic             rsp_err,
  output logic [FLW-1:0]   psr,
  output logic [1:0]       dbg_state
);

  // Handshakes: a request transfers on a cycle where req_valid[i] && req_ready[i];
  // a response transfers on a cycle where rsp_valid[i] && rsp_ready[i].

  logic [1:0]       state_q, state_d;
  logic             winner_q, winner_d;
  logic             err_q, err_d;
  logic             wr_psr_q, wr_psr_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [OPW-1:0]   alu_op_q, alu_op_d;
  logic             alu_cin_q, alu_cin_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [FLW-1:0]   rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q, rsp_err_d;
  logic [FLW-1:0]   psr_q, psr_d;

  logic [1:0]       gnt;
  logic             accept;
  logic             sel;
  logic [OPW-1:0]   sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  assign accept = (state_q == ST_IDLE) && (req_valid != 2'b00);
  assign sel    = gnt[1];
  assign sel_op = sel ? req1_op : req0_op;
  assign sel_a  = sel ? req1_a  : req0_a;
  assign sel_b  = sel ? req1_b  : req0_b;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  always_comb begin
    state_d     = state_q;
    winner_d    = winner_q;
    err_d       = err_q;
    wr_psr_d    = wr_psr_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_cin_d   = alu_cin_q;
    rsp_data_d  = rsp_data_q;
    rsp_flags_d = rsp_flags_q;
    rsp_err_d   = rsp_err_q;
    psr_d       = psr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          winner_d = sel;
          err_d    = !op_legal(sel_op);
          wr_psr_d = req_wr_psr[sel];
          // Illegal opcodes leave the ALU inputs untouched.
          if (op_legal(sel_op)) begin
            alu_a_d   = sel_a;
            alu_b_d   = sel_b;
            alu_op_d  = sel_op;
            alu_cin_d = req_use_c[sel] & psr_q[C_BIT];
          end
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = err_q ? '0 : alu_c;
        rsp_flags_d = err_q ? '0 : alu_flags;
        rsp_err_d   = err_q;
        if (wr_psr_q && !err_q) psr_d = alu_flags;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready[winner_q]) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      winner_q    <= 1'b0;
      err_q       <= 1'b0;
      wr_psr_q    <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_cin_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
      psr_q       <= '0;
    end else begin
      state_q     <= state_d;
      winner_q    <= winner_d;
      err_q       <= err_d;
      wr_psr_q    <= wr_psr_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_cin_q   <= alu_cin_d;
      rsp_data_q  <= rsp_data_d;
      rsp_flags_q <= rsp_flags_d;
      rsp_err_q   <= rsp_err_d;
      psr_q       <= psr_d;
    end
  end

  assign req_ready  = accept ? gnt : 2'b00;
  assign rsp_valid  = (state_q == ST_RESP) ? (winner_q ? 2'b10 : 2'b01) : 2'b00;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;
  assign alu_cin    = alu_cin_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign psr        = psr_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU, transaction-level reference model checked every cycle,
// directed cases with literal expectations, then randomized traffic.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [4:0]  req0_op = '0, req1_op = '0;
  logic [15:0] req0_a = '0, req1_a = '0, req0_b = '0, req1_b = '0;
  logic [1:0]  req_use_c = '0, req_wr_psr = '0;
  logic [15:0] alu_a, alu_b, alu_c;
  logic [4:0]  alu_opcode, alu_flags;
  logic        alu_cin;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready = '0;
  logic [15:0] rsp_data;
  logic [4:0]  rsp_flags, psr;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_share_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req1_op(req1_op), .req0_a(req0_a), .req1_a(req1_a),
    .req0_b(req0_b), .req1_b(req1_b), .req_use_c(req_use_c), .req_wr_psr(req_wr_psr),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
    .alu_c(alu_c), .alu_flags(alu_flags), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err), .psr(psr),
    .dbg_state(dbg_state)
  );

  // Behavioural ALU, returns {flags{C,L,F,Z,N}, result}; unsigned adds return no flags.
  function automatic logic [20:0] alu_model(input logic [4:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic [4:0]  f;
    s = '0;
    r = '0;
    f = '0;
    case (op)
      OP_ADD, OP_ADDC: begin
        s = {1'b0, a} + {1'b0, b} + ((op == OP_ADDC) ? 17'(cin) : 17'd0);
        r = s[15:0];
        f[C_BIT] = s[16];
        f[F_BIT] = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_ADDU:  r = a + b;
      OP_ADDCU: r = a + b + 16'(cin);
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[15:0];
        f[C_BIT] = s[16];
        f[F_BIT] = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_CMP: begin
        f[L_BIT] = a < b;
        f[N_BIT] = $signed(a) < $signed(b);
        f[Z_BIT] = a == b;
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_LSH:  r = a << b[3:0];
      OP_RSH:  r = a >> b[3:0];
      OP_ARSH: r = $signed(a) >>> b[3:0];
      default: begin
        r = 16'hdead;
        f = 5'b11111;
      end
    endcase
    if (op inside {OP_ADD, OP_ADDC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_RSH, OP_ARSH}) begin
      f[Z_BIT] = r == 16'h0;
      f[N_BIT] = r[15];
    end
    return {f, r};
  endfunction

  always_comb {alu_flags, alu_c} = alu_model(alu_opcode, alu_a, alu_b, alu_cin);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one op in flight, tracked by cycles elapsed since its accept.
  int          m_age;
  logic        m_last;
  logic        m_win;
  logic [4:0]  m_psr;
  logic [15:0] m_a, m_b;
  logic [4:0]  m_op;
  logic        m_cin;
  logic        m_wr;
  logic [21:0] exp_q[$];

  always @(negedge clk) begin
    logic [1:0]  e_ready, e_valid;
    logic [20:0] res;
    logic        legal, c_in;
    logic [4:0]  o;
    logic [15:0] a, b;
    int          w;
    if (!rst_n) begin
      m_age = 0; m_last = 1'b1; m_win = 1'b0; m_psr = '0;
      m_a = '0; m_b = '0; m_op = '0; m_cin = 1'b0; m_wr = 1'b0;
      exp_q.delete();
    end else begin
      e_ready = '0;
      e_valid = '0;
      w = 0;
      if (m_age == 0 && req_valid != 2'b00) begin
        if (req_valid == 2'b11) w = m_last ? 0 : 1;
        else                    w = req_valid[1] ? 1 : 0;
        e_ready[w] = 1'b1;
      end
      if (m_age == 2) e_valid[m_win] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(e_ready));
      check("rsp_valid", 32'(rsp_valid), 32'(e_valid));
      check("psr", 32'(psr), 32'(m_psr));
      check("alu_in", {alu_a, 16'h0} | 32'({alu_opcode, alu_cin}), {m_a, 16'h0} | 32'({m_op, m_cin}));
      check("alu_b", 32'(alu_b), 32'(m_b));
      if (m_age == 2 && exp_q.size() > 0)
        check("rsp_payload", 32'({rsp_err, rsp_flags, rsp_data}), 32'(exp_q[0]));
      if (m_age == 0 && req_valid != 2'b00) begin
        o = w ? req1_op : req0_op;
        a = w ? req1_a : req0_a;
        b = w ? req1_b : req0_b;
        c_in = req_use_c[w] & m_psr[C_BIT];
        legal = o inside {OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU, OP_SUB, OP_CMP, OP_AND,
                          OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_RSH, OP_ARSH};
        m_win = w[0];
        m_last = w[0];
        m_wr = req_wr_psr[w] & legal;
        if (legal) begin
          m_a = a; m_b = b; m_op = o; m_cin = c_in;
          res = alu_model(o, a, b, c_in);
          exp_q.push_back({1'b0, res});
        end else begin
          exp_q.push_back({1'b1, 21'h0});
        end
        m_age = 1;
      end else if (m_age == 1) begin
        if (m_wr) m_psr = exp_q[0][20:16];
        m_age = 2;
      end else if (m_age == 2 && rsp_ready[m_win]) begin
        void'(exp_q.pop_front());
        m_age = 0;
      end
    end
  end

  task automatic do_op(input int r, input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic uc, input logic wp, output logic [15:0] d, output logic [4:0] f,
                       output logic e, output int lat, output logic cin_x, output logic [4:0] op_x,
                       output logic [4:0] psr_x);
    int k;
    @(posedge clk); #1;
    if (r == 0) begin req0_op = op; req0_a = a; req0_b = b; end
    else        begin req1_op = op; req1_a = a; req1_b = b; end
    req_use_c[r] = uc; req_wr_psr[r] = wp; rsp_ready[r] = 1'b1; req_valid[r] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready[r] && k < 20);
    check("grant_seen", 32'(req_ready[r]), 32'd1);
    @(posedge clk); #1 req_valid[r] = 1'b0;
    lat = 0; cin_x = 1'b0; op_x = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin cin_x = alu_cin; op_x = alu_opcode; end
    end while (!rsp_valid[r] && lat < 20);
    d = rsp_data; f = rsp_flags; e = rsp_err; psr_x = psr;
    @(posedge clk); #1 rsp_ready[r] = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] d;
    logic [4:0]  f, op_x, psr_x, op;
    logic        e, cin_x;
    int          lat, n, cyc;
    int          g[6];
    logic [4:0]  legal_ops[13];
    legal_ops = '{OP_ADD, OP_ADDU, OP_ADDC, OP_ADDCU, OP_SUB, OP_CMP, OP_AND,
                  OP_OR, OP_XOR, OP_NOT, OP_LSH, OP_RSH, OP_ARSH};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({req_ready, rsp_valid, rsp_err, rsp_flags, psr, dbg_state}), 32'd0);
    check("rst_data", 32'({rsp_data, alu_a}), 32'd0);
    check("rst_alu", 32'({alu_b, alu_opcode, alu_cin}), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // ADD overflow into sign bit
    do_op(0, OP_ADD, 16'h7fff, 16'h0001, 1'b0, 1'b1, d, f, e, lat, cin_x, op_x, psr_x);
    check("t1_data", 32'(d), 32'h8000);
    check("t1_flags", 32'(f), 32'b00101);
    check("t1_psr", 32'(psr_x), 32'b00101);
    check("t1_latency", lat, 2);

    // Carry produced, then consumed by ADDC
    do_op(0, OP_ADD, 16'h0402, 16'hffff, 1'b0, 1'b1, d, f, e, lat, cin_x, op_x, psr_x);
    check("t2a_data", 32'(d), 32'h0401);
    check("t2a_flags", 32'(f), 32'b10000);
    do_op(0, OP_ADDC, 16'h0000, 16'hffff, 1'b1, 1'b1, d, f, e, lat, cin_x, op_x, psr_x);
    check("t2b_cin", 32'(cin_x), 32'd1);
    check("t2b_data", 32'(d), 32'h0000);
    check("t2b_flags", 32'(f), 32'b10010);
    check("t2b_psr", 32'(psr_x), 32'b10010);

    // Compare without PSR write
    do_op(1, OP_CMP, 16'h0001, 16'h0300, 1'b0, 1'b0, d, f, e, lat, cin_x, op_x, psr_x);
    check("t4_data", 32'(d), 32'h0000);
    check("t4_flags", 32'(f), 32'b01001);
    check("t4_psr", 32'(psr_x), 32'b10010);

    // Both requesters saturating: grants must alternate
    @(posedge clk); #1;
    req0_op = OP_AND; req1_op = OP_AND;
    req0_a = 16'h0ff0; req0_b = 16'h00ff; req1_a = 16'hf00f; req1_b = 16'hffff;
    req_use_c = 2'b00; req_wr_psr = 2'b00; rsp_ready = 2'b11; req_valid = 2'b11;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (req_ready == 2'b01) begin g[n] = 0; n++; end
      else if (req_ready == 2'b10) begin g[n] = 1; n++; end
    end
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1 rsp_ready = 2'b00;
    check("t3_grant_count", n, 6);
    for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), g[i], i % 2);

    // Illegal opcode
    do_op(0, 5'b11111, 16'h1234, 16'h5678, 1'b0, 1'b1, d, f, e, lat, cin_x, op_x, psr_x);
    check("t5_err", 32'(e), 32'd1);
    check("t5_data", 32'({d, f}), 32'd0);
    check("t5_alu_opcode", 32'(op_x), 32'(OP_AND));
    check("t5_psr", 32'(psr_x), 32'b10010);

    // Reset while an op is in EXEC
    @(posedge clk); #1;
    req0_op = OP_ADD; req0_a = 16'h8000; req0_b = 16'h8000; req_wr_psr = 2'b01;
    rsp_ready = 2'b01; req_valid = 2'b01;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!req_ready[0] && cyc < 20);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("t6_rsp_valid_rst", 32'(rsp_valid), 32'd0);
      check("t6_psr_rst", 32'(psr), 32'd0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t6_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    req0_op = OP_XOR; req0_a = 16'h00f0; req0_b = 16'h0ff0;
    req1_op = OP_OR;  req1_a = 16'h1111; req1_b = 16'h2222;
    rsp_ready = 2'b11; req_valid = 2'b11;
    @(negedge clk);
    check("t6_tie_grant", 32'(req_ready), 32'b01);
    @(posedge clk); #1 req_valid = 2'b00;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rsp_valid[0] && cyc < 20);
    check("t6_data", 32'(rsp_data), 32'h0f00);
    @(posedge clk); #1 rsp_ready = 2'b00;

    // Random traffic, checked every cycle by the model
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      op = legal_ops[$urandom_range(0, 12)];
      if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(0, 31));
      req0_op = op;
      op = legal_ops[$urandom_range(0, 12)];
      if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(0, 31));
      req1_op = op;
      req0_a = 16'($urandom); req0_b = 16'($urandom);
      req1_a = 16'($urandom); req1_b = 16'($urandom);
      req_use_c = 2'($urandom_range(0, 3));
      req_wr_psr = 2'($urandom_range(0, 3));
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("final_idle", 32'(rsp_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
